// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS-subset core: opcode values as used by the
// control decoder, PC source encodings, and the front-end sequencer states.
package cpu_pkg;

  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] BNE   = 6'b000101;
  localparam logic [5:0] ADDI  = 6'b001000;
  localparam logic [5:0] J     = 6'b000010;
  localparam logic [5:0] HLT   = 6'b111111;

  localparam logic [1:0] PC_SRC_SEQ = 2'b00;  // PC+4
  localparam logic [1:0] PC_SRC_BR  = 2'b01;  // branch target
  localparam logic [1:0] PC_SRC_JMP = 2'b10;  // jump target

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  // Opcodes that read rt as a source operand (addi/lw write rt instead).
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == RTYPE) || (op == SW) || (op == BEQ) || (op == BNE);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in EX and the instruction in ID.
//   ex_mem_read, ex_rt : load in EX and its destination register
//   id_opcode, id_rs, id_rt : instruction in ID
//   stall_req : ID consumes the register the EX load is about to produce
import cpu_pkg::*;

module hazard_detect (
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic [5:0] id_opcode,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       stall_req
);

  // $0 is hardwired, so a load targeting it never creates a dependency.
  assign stall_req = ex_mem_read && (ex_rt != 5'd0) &&
                     ((ex_rt == id_rs) || ((ex_rt == id_rt) && uses_rt(id_opcode)));

endmodule

// File: rtl/pipeline_sequencer.sv
// Front-end controller for the 5-stage core. Drives PC / IF-ID enables,
// IF-ID and ID-EX flushes and PC source; handles load-use stalls, taken
// branches, jumps and halt draining; keeps saturating stall/flush counters.
//   clk, rst_n        : clock, synchronous active-low reset
//   start             : leaves IDLE
//   id_*              : instruction in ID
//   ex_mem_read/ex_rt : load in EX
//   ex_branch_taken   : branch in EX resolved taken
//   pc_en, ifid_en, ifid_flush, idex_flush, pc_src : pipeline controls
//   halted, stall_cnt, flush_cnt : status
import cpu_pkg::*;

module pipeline_sequencer #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       id_opcode,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       pc_src,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_e        state;
  logic [DW-1:0] drain_cnt;
  logic          stall_req;
  logic          run, ev_br, ev_stall, ev_jmp, ev_hlt;

  hazard_detect u_hz (
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .id_opcode   (id_opcode),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .stall_req   (stall_req)
  );

  // Strict priority: a taken branch makes the ID instruction wrong-path,
  // so nothing decoded in ID may act in that cycle.
  assign run      = (state == ST_RUN);
  assign ev_br    = run && ex_branch_taken;
  assign ev_stall = run && !ex_branch_taken && stall_req;
  assign ev_jmp   = run && !ex_branch_taken && !stall_req && (id_opcode == J);
  assign ev_hlt   = run && !ex_branch_taken && !stall_req && (id_opcode == HLT);

  assign halted = (state == ST_HALTED);

  always_comb begin
    // IDLE / DRAIN / HALTED: frozen front end, bubbles into both registers
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b1;
    idex_flush = 1'b1;
    pc_src     = PC_SRC_SEQ;
    if (run) begin
      if (ev_br) begin
        pc_en   = 1'b1;
        ifid_en = 1'b1;
        pc_src  = PC_SRC_BR;
      end else if (ev_stall) begin
        ifid_flush = 1'b0;
      end else if (ev_jmp) begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_flush = 1'b0;
        pc_src     = PC_SRC_JMP;
      end else if (ev_hlt) begin
        // hlt itself moves on into ID/EX as a no-op
        idex_flush = 1'b0;
      end else begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      drain_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) state <= ST_RUN;
        ST_RUN: if (ev_hlt) begin
          state     <= ST_DRAIN;
          drain_cnt <= DW'(DRAIN_CYCLES - 1);
        end
        ST_DRAIN: begin
          // Leave as the count steps to zero so halted rises exactly
          // DRAIN_CYCLES cycles after hlt sat in ID.
          if (drain_cnt <= DW'(1)) begin
            state     <= ST_HALTED;
            drain_cnt <= '0;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        default: state <= ST_HALTED;
      endcase
      if (ev_stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if ((ev_br || ev_jmp) && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
module tb_pipeline_sequencer;

  localparam int DRAIN = 3;
  localparam int CW    = 16;
  localparam int SAT   = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n, start;
  logic [5:0]    id_opcode;
  logic [4:0]    id_rs, id_rt, ex_rt;
  logic          ex_mem_read, ex_branch_taken;
  logic          pc_en, ifid_en, ifid_flush, idex_flush, halted;
  logic [1:0]    pc_src;
  logic [CW-1:0] stall_cnt, flush_cnt;

  pipeline_sequencer #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .pc_src(pc_src), .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Reference model: the block's behaviour as a function of elapsed cycles.
  int cyc = 0;
  int halt_cyc = -1;   // cycle in which hlt was accepted in ID, -1 if none
  bit started = 1'b0;
  int m_stall = 0, m_flush = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // 0 idle, 1 run, 2 drain, 3 halted
  function automatic int mode();
    if (!started) return 0;
    if (halt_cyc < 0) return 1;
    if (cyc - halt_cyc >= DRAIN) return 3;
    return 2;
  endfunction

  // 1 branch, 2 load-use, 3 jump, 4 halt, 5 normal
  function automatic int event_now();
    bit rt_src, hz;
    rt_src = (id_opcode == 6'd0) || (id_opcode == 6'd43) || (id_opcode == 6'd4) || (id_opcode == 6'd5);
    hz = ex_mem_read && (ex_rt != 0) && ((ex_rt == id_rs) || ((ex_rt == id_rt) && rt_src));
    if (ex_branch_taken) return 1;
    if (hz) return 2;
    if (id_opcode == 6'd2) return 3;
    if (id_opcode == 6'd63) return 4;
    return 5;
  endfunction

  task automatic set_in(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic mr, input logic [4:0] ert, input logic br);
    id_opcode = op; id_rs = rs; id_rt = rt;
    ex_mem_read = mr; ex_rt = ert; ex_branch_taken = br;
  endtask

  // One clock: compare at the falling edge, advance the model on the rising one.
  task automatic cycle(input bit chk);
    int m, e;
    logic pe, ie, fi, fx;
    logic [1:0] ps;
    bit ie_c, fi_c, ps_c;
    @(negedge clk);
    m = mode();
    e = event_now();
    pe = 0; ie = 0; fi = 1; fx = 1; ps = 2'b00;
    ie_c = 1; fi_c = 1; ps_c = (m == 0);
    if (m == 1) begin
      case (e)
        1: begin pe = 1; ps = 2'b01; ie_c = 0; ps_c = 1; end
        2: begin fi_c = 0; end
        3: begin pe = 1; ps = 2'b10; fx = 0; ie_c = 0; ps_c = 1; end
        4: begin fx = 0; ie_c = 0; end
        default: begin pe = 1; ie = 1; fi = 0; fx = 0; ps_c = 1; end
      endcase
    end
    if (chk) begin
      check("pc_en", pc_en, pe);
      if (ie_c) check("ifid_en", ifid_en, ie);
      if (fi_c) check("ifid_flush", ifid_flush, fi);
      check("idex_flush", idex_flush, fx);
      if (ps_c) check("pc_src", pc_src, ps);
      check("halted", halted, (m == 3));
      check("stall_cnt", stall_cnt, m_stall);
      check("flush_cnt", flush_cnt, m_flush);
    end
    if (!rst_n) begin
      started = 0; halt_cyc = -1; m_stall = 0; m_flush = 0;
    end else if (m == 0) begin
      if (start) started = 1;
    end else if (m == 1) begin
      if (e == 2 && m_stall < SAT) m_stall++;
      if ((e == 1 || e == 3) && m_flush < SAT) m_flush++;
      if (e == 4) halt_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 0;
    cycle(0);
    rst_n = 1;
  endtask

  logic [5:0] ops [12] = '{6'd0, 6'd0, 6'd35, 6'd35, 6'd43, 6'd4, 6'd5, 6'd8, 6'd8, 6'd2, 6'd63, 6'd13};

  initial begin
    rst_n = 0; start = 1;
    set_in(6'd0, 0, 0, 0, 0, 0);
    // start held through reset and released together with it: must stay IDLE
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1; start = 0;
    cycle(1); cycle(1);

    start = 1; cycle(1); start = 0;                  // IDLE -> RUN
    cycle(1);
    set_in(6'd0, 5, 1, 1, 5, 0);  cycle(1);          // lw $5 -> add rs=$5: stall
    set_in(6'd0, 0, 0, 0, 0, 0);  cycle(1);          // lw moved on: no more stall
    set_in(6'd0, 0, 0, 1, 0, 0);  cycle(1);          // ex_rt = 0: no stall
    set_in(6'd8, 1, 7, 1, 7, 0);  cycle(1);          // addi rt match: no stall
    set_in(6'd43, 1, 7, 1, 7, 0); cycle(1);          // sw rt match: stall
    set_in(6'd63, 5, 1, 1, 5, 1); cycle(1);          // branch beats stall and hlt
    set_in(6'd0, 0, 0, 0, 0, 0);  cycle(1);
    set_in(6'd2, 0, 0, 0, 0, 0);  cycle(1);          // jump
    set_in(6'd0, 0, 0, 0, 0, 0);  cycle(1);
    set_in(6'd63, 0, 0, 0, 0, 0); cycle(1);          // hlt in ID at N
    set_in(6'd0, 0, 0, 0, 0, 1);                     // branch ignored while draining
    for (int i = 0; i < 6; i++) begin
      start = i[0];                                  // start pulses ignored
      cycle(1);
    end
    start = 0;

    // reset in the middle of a drain
    do_reset();
    start = 1; cycle(1); start = 0;
    set_in(6'd2, 0, 0, 0, 0, 0); cycle(1);
    set_in(6'd63, 0, 0, 0, 0, 0); cycle(1);          // N
    set_in(6'd0, 0, 0, 0, 0, 0);
    rst_n = 0; cycle(1);                              // N+1
    rst_n = 1; cycle(1); cycle(1);                   // N+2: IDLE, counters 0

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      set_in(ops[$urandom_range(0, 11)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 7) == 0));
      start = ($urandom_range(0, 2) == 0);
      rst_n = !((mode() == 3 && $urandom_range(0, 5) == 0) || $urandom_range(0, 299) == 0);
      cycle(1);
    end
    rst_n = 1; start = 0;

    // stall counter saturation
    do_reset();
    start = 1; cycle(1); start = 0;
    set_in(6'd0, 9, 0, 1, 9, 0);
    for (int i = 0; i < SAT + 6; i++) cycle(0);
    cycle(1);
    check("stall_sat", stall_cnt, SAT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Central pipeline controller for the 5-stage MIPS-subset processor. It sits beside the opcode decoder in ID and sequences the front end. It generates the PC/IF-ID enables, the IF/ID and ID/EX flushes and the PC source select. It detects load-use hazards, handles taken branches and jumps, drains the pipeline on `hlt`, and keeps stall/flush performance counters.

## Interface
- `DRAIN_CYCLES`, 3: cycles after `hlt` leaves ID until it has retired from WB.
- `CNT_W`, 16: width of the performance counters.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  single-cycle pulse that leaves IDLE.
- `id_opcode`  in  6  opcode of the instruction in ID.
- `id_rs`, `id_rt`  in  5  source register fields in ID.
- `ex_mem_read`  in  1  instruction in EX is `lw` (its MemtoReg).
- `ex_rt`  in  5  destination register of the instruction in EX.
- `ex_branch_taken`  in  1  `beq`/`bne` in EX resolved taken.
- `pc_en`  out  1  PC register load enable.
- `ifid_en`  out  1  IF/ID register load enable.
- `ifid_flush`  out  1  load a bubble (all zero) into IF/ID.
- `idex_flush`  out  1  load a bubble (all control bits zero) into ID/EX.
- `pc_src`  out  2  PC source: 00 = PC+4, 01 = branch target, 10 = jump target.
- `halted`  out  1  high while in HALTED.
- `stall_cnt`, `flush_cnt`  out  CNT_W  saturating event counters.

## Operation
- States:
  - IDLE: reset state.
  - RUN: normal execution.
  - DRAIN: `hlt` has passed ID; the older instructions are retiring.
  - HALTED: terminal; only reset leaves it.
- IDLE → RUN on `start`. In IDLE the outputs are `pc_en=0`, `ifid_en=0`, `ifid_flush=1`, `idex_flush=1`, `pc_src=00`.
- In RUN, events are evaluated every cycle in strict priority order:
  1. Branch redirect, when `ex_branch_taken`. Outputs: `pc_src=01`, `pc_en=1`, `ifid_flush=1`, `idex_flush=1`. The ID instruction is wrong-path, so any stall, jump or halt in ID is ignored.
  2. Load-use stall. Condition: `ex_mem_read`, `ex_rt!=0`, and either `ex_rt==id_rs` or (`ex_rt==id_rt` and `id_opcode` uses rt). Opcodes that use rt: R-type 000000, `sw` 101011, `beq` 000100, `bne` 000101. Outputs: `pc_en=0`, `ifid_en=0`, `idex_flush=1`.
  3. Jump, when `id_opcode==000010`. Outputs: `pc_src=10`, `pc_en=1`, `ifid_flush=1`.
  4. Halt, when `id_opcode==111111`. Outputs: `pc_en=0`, `ifid_flush=1`. `hlt` itself advances into ID/EX, where it acts as a no-op. Next state is DRAIN, and the drain counter loads `DRAIN_CYCLES-1`.
  5. Otherwise: `pc_en=1`, `ifid_en=1`, `pc_src=00`, no flushes.
- DRAIN:
  - Outputs: `pc_en=0`, `ifid_en=0`, `ifid_flush=1`, `idex_flush=1`.
  - The counter decrements each cycle; when it reaches 0 the next state is HALTED.
  - `ex_branch_taken` is ignored. `hlt` always sits behind any branch that was in flight.
- HALTED: same outputs as DRAIN, plus `halted=1`. `start` is ignored.
- Counters:
  - `stall_cnt` increments once per cycle in which event 2 is selected.
  - `flush_cnt` increments once per cycle in which event 1 or event 3 is selected.
  - Both saturate at all-ones and never wrap.

## Timing
- Enables, flushes and `pc_src` are combinational from the current state and the ID/EX inputs, so they act at the same rising edge as the hazard.
- State, the drain counter and the performance counters are registered.
- Reset values: state IDLE, drain counter 0, `halted=0`, `stall_cnt=0`, `flush_cnt=0`. Outputs take their IDLE values.
- Reset asserted mid-DRAIN or in HALTED returns the block to IDLE on the next edge, with no residual count.
- Latencies:
  - Load-use stall: exactly one bubble, because the `lw` moves on to MEM on the next cycle.
  - Taken branch: two bubbles.
  - Jump: one bubble.
- `halted` rises exactly `DRAIN_CYCLES` cycles after the cycle in which `hlt` was in ID.
- `start` arriving in the same cycle as reset release is ignored.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants: RTYPE, LW, SW, BEQ, BNE, ADDI, J, HLT (the same values the control decoder uses);
  - `pc_src` encodings;
  - the state enum.
- Sub-module `hazard_detect`: purely combinational load-use compare, output `stall_req`. Used by the sequencer's priority logic.

## Test plan
- Load-use stall: `lw $5` in EX (`ex_mem_read=1`, `ex_rt=5`) with `add` in ID (`id_rs=5`) → one cycle with `pc_en=0`, `ifid_en=0`, `idex_flush=1`; `stall_cnt` becomes 1. Repeat with `ex_rt=0` → no stall.
- rt-use rules: `ex_rt==id_rt` with ID=`addi` → no stall; with ID=`sw` → stall.
- Branch over hazard: `ex_branch_taken=1` while the load-use condition and `id_opcode=111111` are both present → `pc_src=01`, both flushes high, no stall, state stays RUN; `flush_cnt` +1.
- Jump: `id_opcode=000010` → `pc_src=10`, `ifid_flush=1`, `idex_flush=0`.
- Halt drain: `hlt` in ID at cycle N with `DRAIN_CYCLES=3` → `pc_en=0` from cycle N, `halted=1` from cycle N+3, and it stays high despite `start` pulses. Assert `rst_n=0` at N+1 → IDLE at N+2, counters at 0.
- Counter saturation: force 2^CNT_W + 5 stall cycles → `stall_cnt` holds all-ones.
